// File: rtl/audio_pkg.sv
// audio_pkg: shared constants and types for the audio output path.
package audio_pkg;

  localparam int DEFAULT_SAMPLE_W = 16;

  typedef logic signed [DEFAULT_SAMPLE_W-1:0] sample_t;

  // I2S word-select values
  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous FIFO for audio samples, async active-low reset.
// DEPTH must be a power of two so the pointers wrap naturally.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int W     = DEFAULT_SAMPLE_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;

  // Sample storage carries no reset; occupancy is tracked by level_q.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Occupancy changes only when exactly one of push/pop happens.
  always_comb begin
    level_d = level_q;
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (level_q == LVL_FULL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: buffers mono samples and serialises each one into both the
// left and right slots of an I2S frame (BCLK / LRCLK / SDATA).
// Build option AUDIO_I2S_UNDERRUN_HOLD_EN: on underrun repeat the last popped
// sample instead of sending silence.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = DEFAULT_SAMPLE_W,
  parameter int BCLK_DIV   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [SAMPLE_W-1:0]          s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic                         bclk,
  output logic                         lrclk,
  output logic                         sdata,
  output logic                         underrun,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int FW  = 2 * SAMPLE_W;
  localparam int BCW = $clog2(FW);
  localparam int DW  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_TC    = DW'(BCLK_DIV - 1);
  localparam logic [BCW-1:0] BC_LAST   = BCW'(FW - 1);
  localparam logic [BCW-1:0] BC_RSTART = BCW'(SAMPLE_W);

  logic [DW-1:0]  div_q, div_d;
  logic           bclk_q, bclk_d;
  logic [BCW-1:0] bc_q, bc_d;
  logic           lrclk_q, lrclk_d;
  logic [FW-1:0]  sr_q, sr_d;
  logic           underrun_q, underrun_d;
`ifdef AUDIO_I2S_UNDERRUN_HOLD_EN
  logic [SAMPLE_W-1:0] last_q, last_d;
`endif

  logic                div_tc, fall_ev, load_ev;
  logic                push, pop;
  logic                fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0] fifo_dout;

  assign div_tc  = (div_q == DIV_TC);
  assign fall_ev = div_tc && bclk_q;
  // Frame load happens on the fall event that moves bc from 0 to 1.
  assign load_ev = fall_ev && (bc_q == '0);
  assign push    = s_valid && s_ready;
  // The empty check uses the registered level, so a same-edge push is never bypassed.
  assign pop     = load_ev && !fifo_empty;

  sample_fifo #(
    .W     (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .data_i  (s_data),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Next-state for divider, bit counter, word select and shift register.
  always_comb begin
    div_d      = div_tc ? '0 : div_q + 1'b1;
    bclk_d     = div_tc ? ~bclk_q : bclk_q;
    bc_d       = bc_q;
    lrclk_d    = lrclk_q;
    sr_d       = sr_q;
    underrun_d = 1'b0;
`ifdef AUDIO_I2S_UNDERRUN_HOLD_EN
    last_d     = last_q;
`endif
    if (fall_ev) begin
      bc_d    = (bc_q == BC_LAST) ? '0 : bc_q + 1'b1;
      lrclk_d = (bc_d >= BC_RSTART) ? RIGHT : LEFT;
      if (load_ev) begin
        if (!fifo_empty) begin
          sr_d = {fifo_dout, fifo_dout};
`ifdef AUDIO_I2S_UNDERRUN_HOLD_EN
          last_d = fifo_dout;
`endif
        end else begin
          underrun_d = 1'b1;
`ifdef AUDIO_I2S_UNDERRUN_HOLD_EN
          sr_d = {last_q, last_q};
`else
          sr_d = '0;
`endif
        end
      end else begin
        sr_d = {sr_q[FW-2:0], 1'b0};
      end
    end
  end

  // State registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= '0;
      bclk_q     <= 1'b0;
      bc_q       <= '0;
      lrclk_q    <= LEFT;
      sr_q       <= '0;
      underrun_q <= 1'b0;
`ifdef AUDIO_I2S_UNDERRUN_HOLD_EN
      last_q     <= '0;
`endif
    end else begin
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      bc_q       <= bc_d;
      lrclk_q    <= lrclk_d;
      sr_q       <= sr_d;
      underrun_q <= underrun_d;
`ifdef AUDIO_I2S_UNDERRUN_HOLD_EN
      last_q     <= last_d;
`endif
    end
  end

  assign s_ready  = !fifo_full;
  assign bclk     = bclk_q;
  assign lrclk    = lrclk_q;
  assign sdata    = sr_q[FW-1];
  assign underrun = underrun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: random and directed stimulus against a timing model of the
// I2S frame computed from the clock count since reset release.
module tb_audio_i2s_tx;
  import audio_pkg::*;

  localparam int SW    = 16;
  localparam int DIV   = 2;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int STEP  = 2 * DIV;        // clk per BCLK period / per bit
  localparam int FRAME = 2 * SW * STEP;  // clk per frame
`ifdef AUDIO_I2S_UNDERRUN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [SW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready, bclk, lrclk, sdata, underrun;
  logic [LW-1:0] fifo_level;

  audio_i2s_tx #(.SAMPLE_W(SW), .BCLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model state
  sample_t          fifo_m[$];
  sample_t          src_q[$];
  logic [2*SW-1:0]  word_m;
  sample_t          last_m;
  int               cyc;
  int               bc_m;
  int               valid_pct = 100;
  bit               ur_m, load_m, push_m;

  // captured frames (one per load event) and underrun flag at each load
  logic [2*SW-1:0]  frames_got[$];
  logic             ur_got[$];
  logic [2*SW-1:0]  cap;
  bit               cap_on;

  function automatic logic [2*SW-1:0] ur_frame(input logic [SW-1:0] last);
    return {last, last} & {(2*SW){HOLD}};
  endfunction

  task automatic clear_frames();
    frames_got.delete();
    ur_got.delete();
    cap_on = 1'b0;
  endtask

  task automatic model_reset();
    fifo_m.delete();
    word_m = '0;
    last_m = '0;
    cyc    = 0;
    bc_m   = 0;
    ur_m   = 1'b0;
    load_m = 1'b0;
    push_m = 1'b0;
    clear_frames();
  endtask

  // One clock: advance the model at the edge, compare at the falling edge,
  // then drive the next input.
  task automatic tick();
    bit ready_pre;
    @(posedge clk);
    cyc++;
    ready_pre = (fifo_m.size() < DEPTH);
    push_m    = s_valid && ready_pre;
    bc_m      = (cyc / STEP) % (2 * SW);
    load_m    = ((cyc % STEP) == 0) && (bc_m == 1);
    ur_m      = 1'b0;
    if (load_m) begin
      if (fifo_m.size() > 0) begin
        last_m = fifo_m.pop_front();
        word_m = {last_m, last_m};
      end else begin
        ur_m   = 1'b1;
        word_m = ur_frame(last_m);
      end
    end
    if (push_m) begin
      fifo_m.push_back(s_data);
      src_q.delete(0);
    end
    @(negedge clk);
    chk("bclk",       32'(bclk),       32'((cyc / DIV) % 2));
    chk("lrclk",      32'(lrclk),      32'(bc_m >= SW));
    chk("sdata",      32'(sdata),      32'(word_m[2*SW-1 - ((bc_m + 2*SW - 1) % (2*SW))]));
    chk("underrun",   32'(underrun),   32'(ur_m));
    chk("fifo_level", 32'(fifo_level), 32'(fifo_m.size()));
    chk("s_ready",    32'(s_ready),    32'(fifo_m.size() < DEPTH));
    if (load_m) begin
      cap_on = 1'b1;
      cap    = '0;
      ur_got.push_back(underrun);
    end
    if (cap_on && (cyc % STEP) == 0) begin
      cap = {cap[2*SW-2:0], sdata};
      if (bc_m == 0) frames_got.push_back(cap);
    end
    if (!(s_valid && !push_m)) begin
      if (src_q.size() > 0 && int'($urandom_range(99, 0)) < valid_pct) begin
        s_valid = 1'b1;
        s_data  = src_q[0];
      end else begin
        s_valid = 1'b0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_load(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!load_m && n < FRAME + 8);
    if (!load_m) chk({tag, "_timeout"}, 32'(0), 32'(1));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset   = 1'b0;
    s_valid = 1'b0;
    src_q.delete();
    #1;
    chk({tag, "_bclk"},     32'(bclk),       32'(0));
    chk({tag, "_lrclk"},    32'(lrclk),      32'(0));
    chk({tag, "_sdata"},    32'(sdata),      32'(0));
    chk({tag, "_underrun"}, 32'(underrun),   32'(0));
    chk({tag, "_level"},    32'(fifo_level), 32'(0));
    chk({tag, "_ready"},    32'(s_ready),    32'(1));
    repeat (3) @(negedge clk);
    model_reset();
    reset = 1'b1;
  endtask

  task automatic chk_frame(input string tag, input int i, input logic [2*SW-1:0] expf,
                           input logic expu);
    if (frames_got.size() > i) begin
      chk({tag, "_data"}, frames_got[i], expf);
      chk({tag, "_ur"},   32'(ur_got[i]), 32'(expu));
    end else begin
      chk({tag, "_missing"}, 32'(frames_got.size()), 32'(i + 1));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();

    // idle after reset: silence with one underrun per frame
    do_reset("rst0");
    run(2 * FRAME + 8);
    chk_frame("idle0", 0, '0, 1'b1);
    chk_frame("idle1", 1, '0, 1'b1);

    // single sample into an empty FIFO
    wait_load("single");
    clear_frames();
    src_q.push_back(16'hA5C3);
    run(3 * FRAME);
    chk_frame("single0", 0, 32'hA5C3A5C3, 1'b0);
    chk_frame("single1", 1, ur_frame(16'hA5C3), 1'b1);
    chk("single_level", 32'(fifo_level), 32'(0));

    // backpressure: five samples into a four-entry FIFO
    do_reset("rst1");
    wait_load("full");
    clear_frames();
    for (int v = 1; v <= 5; v++) src_q.push_back(sample_t'(v));
    run(6);
    chk("full_ready", 32'(s_ready), 32'(0));
    chk("full_level", 32'(fifo_level), 32'(DEPTH));
    wait_load("full_pop");
    chk("refill_ready", 32'(s_ready), 32'(1));
    run(6 * FRAME);
    for (int v = 1; v <= 5; v++)
      chk_frame($sformatf("full%0d", v), v - 1, {16'(v), 16'(v)}, 1'b0);
    chk_frame("full_ur", 5, ur_frame(16'd5), 1'b1);

    // underrun and recovery
    wait_load("urec");
    clear_frames();
    src_q.push_back(16'h7FFF);
    run(2 * FRAME + 8);
    src_q.push_back(16'h1234);
    run(2 * FRAME);
    chk_frame("urec0", 0, 32'h7FFF7FFF, 1'b0);
    chk_frame("urec1", 1, ur_frame(16'h7FFF), 1'b1);
    chk_frame("urec2", 2, 32'h12341234, 1'b0);

    // reset in the middle of a frame with samples queued
    do_reset("rst2");
    wait_load("mid");
    for (int v = 0; v < 3; v++) src_q.push_back(sample_t'(16'h1111 * (v + 1)));
    for (int i = 0; i < 100 && bc_m != 9; i++) tick();
    chk("mid_bc9", 32'(bc_m), 32'(9));
    chk("mid_pre_level", 32'(fifo_level), 32'(3));
    do_reset("midrst");
    run(FRAME + 8);
    chk_frame("mid_after", 0, '0, 1'b1);

    // push landing on the load edge with the FIFO empty
    do_reset("rst3");
    run(2);
    src_q.push_back(16'hBEEF);
    run(2);
    chk("coinc_load", 32'(load_m), 32'(1));
    chk("coinc_ur", 32'(underrun), 32'(1));
    chk("coinc_level", 32'(fifo_level), 32'(1));
    run(2 * FRAME + 8);
    chk_frame("coinc0", 0, '0, 1'b1);
    chk_frame("coinc1", 1, 32'hBEEFBEEF, 1'b0);

    // random traffic with varying input duty
    do_reset("rst4");
    for (int r = 0; r < 3; r++) begin
      valid_pct = int'($urandom_range(100, 20));
      for (int i = 0; i < 10; i++) src_q.push_back(sample_t'($urandom_range(16'hFFFF, 0)));
      run(10 * FRAME + 200);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
